// File: rtl/sha256_padder_pkg.sv
// Shared constants and state encodings for the SHA-256 byte-serial padder.
package sha256_padder_pkg;

  localparam int unsigned BlockBits = 512;
  localparam logic [7:0]  PadByte   = 8'h80;
  localparam int unsigned LenOffset = 56;

  typedef enum logic [1:0] {
    StFill = 2'd0,
    StPad  = 2'd1,
    StEmit = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    FillPad     = 2'd0,
    FillExtra80 = 2'd1,
    FillExtra00 = 2'd2
  } fill_mode_e;

endpackage

// File: rtl/sha256_pad_fill.sv
// Combinational next-buffer image for the pad step and for the trailing length-only block.
module sha256_pad_fill
  import sha256_padder_pkg::*;
(
  input  logic [BlockBits-1:0] cur_buf,
  input  logic [6:0]           pos,
  input  logic [63:0]          bitlen,
  input  fill_mode_e           mode,
  output logic [BlockBits-1:0] next_buf
);

  always_comb begin
    next_buf = cur_buf;
    unique case (mode)
      FillPad: begin
        for (int i = 0; i < 64; i++) begin
          if (7'(i) == pos) begin
            next_buf[511 - 8*i -: 8] = PadByte;
          end else if (7'(i) > pos) begin
            next_buf[511 - 8*i -: 8] = 8'h00;
          end
        end
        // Length only fits in this block when the pad byte landed at or before byte 55.
        if (pos <= 7'(LenOffset - 1)) begin
          next_buf[63:0] = bitlen;
        end
      end
      FillExtra80: next_buf = {PadByte, 440'h0, bitlen};
      FillExtra00: next_buf = {8'h00, 440'h0, bitlen};
      default:     next_buf = cur_buf;
    endcase
  end

endmodule

// File: rtl/sha256_padder.sv
// Byte-serial SHA-256 front end: buffers bytes, applies FIPS 180-4 padding, emits 512-bit blocks.
module sha256_padder
  import sha256_padder_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic                 in_keep,
  output logic                 in_ready,
  output logic [BlockBits-1:0] block,
  output logic                 block_valid,
  input  logic                 block_ready,
  output logic                 block_first,
  output logic                 block_last
);

  state_e               state_q, state_d;
  logic [BlockBits-1:0] buf_q, buf_d;
  logic [6:0]           pos_q, pos_d;
  logic [63:0]          bitlen_q, bitlen_d;
  logic                 first_pend_q, first_pend_d;
  logic                 final_q, final_d;
  logic                 extra_q, extra_d;
  logic [6:0]           pos_at_pad_q, pos_at_pad_d;

  logic [BlockBits-1:0] fill_buf;
  fill_mode_e           fill_mode;
  logic [8:0]           wr_lsb;

  always_comb begin
    if (state_q == StPad) begin
      fill_mode = FillPad;
    end else if (pos_at_pad_q == 7'd64) begin
      fill_mode = FillExtra80;
    end else begin
      fill_mode = FillExtra00;
    end
  end

  sha256_pad_fill u_pad_fill (
    .cur_buf  (buf_q),
    .pos      (pos_q),
    .bitlen   (bitlen_q),
    .mode     (fill_mode),
    .next_buf (fill_buf)
  );

  assign block       = buf_q;
  assign block_first = first_pend_q;
  assign block_last  = final_q;
  assign in_ready    = (state_q == StFill);
  assign block_valid = (state_q == StEmit);
  // Byte 0 sits in the top lane, so lane index is reversed.
  assign wr_lsb      = {6'd63 - pos_q[5:0], 3'b000};

  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    pos_d        = pos_q;
    bitlen_d     = bitlen_q;
    first_pend_d = first_pend_q;
    final_d      = final_q;
    extra_d      = extra_q;
    pos_at_pad_d = pos_at_pad_q;
    unique case (state_q)
      StFill: begin
        if (in_valid) begin
          if (!in_last || in_keep) begin
            buf_d[wr_lsb +: 8] = in_data;
            pos_d              = pos_q + 7'd1;
            bitlen_d           = bitlen_q + 64'd8;
          end
          if (in_last) begin
            state_d = StPad;
          end else if (pos_d == 7'd64) begin
            state_d = StEmit;
            final_d = 1'b0;
            extra_d = 1'b0;
          end
        end
      end
      StPad: begin
        buf_d = fill_buf;
        if (pos_q <= 7'(LenOffset - 1)) begin
          final_d = 1'b1;
        end else begin
          final_d      = 1'b0;
          extra_d      = 1'b1;
          pos_at_pad_d = pos_q;
        end
        state_d = StEmit;
      end
      StEmit: begin
        if (block_ready) begin
          first_pend_d = 1'b0;
          if (final_q) begin
            pos_d        = 7'd0;
            bitlen_d     = 64'd0;
            first_pend_d = 1'b1;
            final_d      = 1'b0;
            state_d      = StFill;
          end else if (extra_q) begin
            buf_d   = fill_buf;
            final_d = 1'b1;
            extra_d = 1'b0;
          end else begin
            pos_d   = 7'd0;
            state_d = StFill;
          end
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFill;
      buf_q        <= '0;
      pos_q        <= 7'd0;
      bitlen_q     <= 64'd0;
      first_pend_q <= 1'b1;
      final_q      <= 1'b0;
      extra_q      <= 1'b0;
      pos_at_pad_q <= 7'd0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      pos_q        <= pos_d;
      bitlen_q     <= bitlen_d;
      first_pend_q <= first_pend_d;
      final_q      <= final_d;
      extra_q      <= extra_d;
      pos_at_pad_q <= pos_at_pad_d;
    end
  end

endmodule

// File: tb/tb_sha256_padder.sv
// Directed bench for sha256_padder: known-answer padded blocks, flags, timing and reset.
module tb_sha256_padder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   in_data = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic         in_keep = 1'b0;
  logic         in_ready;
  logic [511:0] block;
  logic         block_valid;
  logic         block_ready = 1'b0;
  logic         block_first;
  logic         block_last;

  int checks = 0;
  int failures = 0;

  sha256_padder dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_keep     (in_keep),
    .in_ready    (in_ready),
    .block       (block),
    .block_valid (block_valid),
    .block_ready (block_ready),
    .block_first (block_first),
    .block_last  (block_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic keep);
    int budget;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    in_keep  = keep;
    budget   = 0;
    while (!in_ready && budget < 200) begin
      tick();
      budget++;
    end
    checks++;
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_keep  = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int budget;
    budget = 0;
    while (!block_valid && budget < 200) begin
      tick();
      budget++;
    end
    checks++;
    if (!block_valid) begin
      failures++;
      $display("FAIL %s_valid_timeout: block_valid=%0b required 1", name, block_valid);
    end
  endtask

  task automatic take();
    block_ready = 1'b1;
    tick();
    block_ready = 1'b0;
  endtask

  task automatic check_block(input string name, input logic [511:0] exp,
                             input logic first, input logic last);
    checks++;
    if (block !== exp) begin
      failures++;
      $display("FAIL %s_block: got %h required %h", name, block, exp);
    end
    checks++;
    if (block_first !== first) begin
      failures++;
      $display("FAIL %s_first: got %0b required %0b", name, block_first, first);
    end
    checks++;
    if (block_last !== last) begin
      failures++;
      $display("FAIL %s_last: got %0b required %0b", name, block_last, last);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (block_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid: got %0b required 0", block_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %0b required 1", in_ready);
    end
    check_block("reset", 512'h0, 1'b1, 1'b0);
  endtask

  task automatic test_abc();
    send(8'h61, 1'b0, 1'b1);
    send(8'h62, 1'b0, 1'b1);
    send(8'h63, 1'b1, 1'b1);
    checks++;
    if (block_valid !== 1'b0) begin
      failures++;
      $display("FAIL abc_pad_cycle_valid: got %0b required 0", block_valid);
    end
    tick();
    checks++;
    if (block_valid !== 1'b1) begin
      failures++;
      $display("FAIL abc_latency_valid: got %0b required 1", block_valid);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL abc_emit_in_ready: got %0b required 0", in_ready);
    end
    check_block("abc", {32'h61626380, 448'h0, 32'h00000018}, 1'b1, 1'b1);
    take();
    checks++;
    if (in_ready !== 1'b1 || block_valid !== 1'b0) begin
      failures++;
      $display("FAIL abc_after_take: in_ready=%0b valid=%0b required 1 0", in_ready, block_valid);
    end
  endtask

  task automatic test_empty();
    send(8'h00, 1'b1, 1'b0);
    wait_valid("empty");
    check_block("empty", {32'h80000000, 480'h0}, 1'b1, 1'b1);
    take();
  endtask

  task automatic test_56();
    logic [511:0] exp;
    exp = '0;
    for (int i = 0; i < 56; i++) begin
      exp[511 - 8*i -: 8] = 8'(i + 1);
      send(8'(i + 1), (i == 55), 1'b1);
    end
    exp[511 - 8*56 -: 8] = 8'h80;
    wait_valid("m56");
    check_block("m56_a", exp, 1'b1, 1'b0);
    take();
    checks++;
    if (block_valid !== 1'b1) begin
      failures++;
      $display("FAIL m56_no_gap: block_valid=%0b required 1", block_valid);
    end
    check_block("m56_b", {448'h0, 64'h1C0}, 1'b0, 1'b1);
    take();
    checks++;
    if (block_valid !== 1'b0) begin
      failures++;
      $display("FAIL m56_done_valid: got %0b required 0", block_valid);
    end
  endtask

  task automatic test_64();
    logic [511:0] exp;
    for (int i = 0; i < 64; i++) begin
      exp[511 - 8*i -: 8] = 8'(8'hA0 + i);
      send(8'(8'hA0 + i), (i == 63), 1'b1);
    end
    wait_valid("m64");
    check_block("m64_a", exp, 1'b1, 1'b0);
    take();
    checks++;
    if (block_valid !== 1'b1) begin
      failures++;
      $display("FAIL m64_no_gap: block_valid=%0b required 1", block_valid);
    end
    check_block("m64_b", {8'h80, 440'h0, 64'h200}, 1'b0, 1'b1);
    take();
  endtask

  task automatic test_backpressure_reset();
    int bad;
    send(8'h61, 1'b0, 1'b1);
    send(8'h62, 1'b0, 1'b1);
    send(8'h63, 1'b1, 1'b1);
    wait_valid("bp");
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (block !== {32'h61626380, 448'h0, 32'h00000018} || block_first !== 1'b1 ||
          block_last !== 1'b1 || block_valid !== 1'b1 || in_ready !== 1'b0) begin
        bad++;
      end
      tick();
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_stable: unstable_cycles=%0d required 0", bad);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (block_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_reset: valid=%0b in_ready=%0b required 0 1", block_valid, in_ready);
    end
    test_abc();
  endtask

  task automatic test_back_to_back();
    send(8'h61, 1'b0, 1'b1);
    send(8'h62, 1'b0, 1'b1);
    send(8'h63, 1'b1, 1'b1);
    wait_valid("b2b1");
    check_block("b2b1", {32'h61626380, 448'h0, 32'h00000018}, 1'b1, 1'b1);
    take();
    send(8'h64, 1'b0, 1'b1);
    send(8'h65, 1'b0, 1'b1);
    send(8'h66, 1'b1, 1'b1);
    wait_valid("b2b2");
    check_block("b2b2", {32'h64656680, 448'h0, 32'h00000018}, 1'b1, 1'b1);
    take();
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_56();
    test_64();
    test_backpressure_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
